// File: rtl/mux_pkg.sv
// Shared constants for the stream multiplexer family.
package mux_pkg;

    localparam int unsigned MODE_SEL = 0;
    localparam int unsigned MODE_RR  = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [SELW-1:0] idx_o,
    output logic            any_o
);

    // One extra bit so ptr + k cannot overflow before the modulo-N fold.
    always_comb begin
        logic [SELW:0] pos;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = {1'b0, ptr_i} + (SELW+1)'(k);
            if (pos >= (SELW+1)'(N)) begin
                pos = pos - (SELW+1)'(N);
            end
            if (!any_o && req_i[pos[SELW-1:0]]) begin
                any_o                = 1'b1;
                gnt_o[pos[SELW-1:0]] = 1'b1;
                idx_o                = pos[SELW-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_stream.sv
// N-channel valid/ready stream mux with a registered output stage; channel chosen
// by explicit select or by round-robin arbitration among valid inputs.
module mux_stream
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned N     = 4,
    parameter  int unsigned MODE  = MODE_SEL,
    localparam int unsigned SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SELW-1:0]      sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    input  logic                 out_ready
);

    logic             free_c;
    logic             xfer_c;
    logic [N-1:0]     pick_c;
    logic [SELW-1:0]  ch_c;
    logic [WIDTH-1:0] data_c;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;

    if (MODE == MODE_RR) begin : g_rr
        logic [SELW-1:0] ptr_q, ptr_d;
        logic            unused_any;
        logic            unused_sel;

        assign unused_sel = ^sel;

        rr_pick #(
            .N    (N),
            .SELW (SELW)
        ) u_pick (
            .req_i (in_valid),
            .ptr_i (ptr_q),
            .gnt_o (pick_c),
            .idx_o (ch_c),
            .any_o (unused_any)
        );

        // Pointer moves just past the granted channel, folding at N rather than 2^SELW.
        always_comb begin
            ptr_d = ptr_q;
            if (xfer_c) begin
                ptr_d = (ch_c == SELW'(N - 1)) ? '0 : ch_c + SELW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end
    end else begin : g_sel
        // Out-of-range select decodes to no channel at all.
        always_comb begin
            pick_c = '0;
            for (int unsigned i = 0; i < N; i++) begin
                pick_c[i] = (32'(sel) == i);
            end
        end

        assign ch_c = sel;
    end

    always_comb begin
        free_c   = !out_valid_q || out_ready;
        in_ready = free_c ? pick_c : '0;
        xfer_c   = |(in_valid & in_ready);
        data_c   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pick_c[i]) begin
                data_c = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (free_c) begin
            out_valid_d = xfer_c;
            if (xfer_c) begin
                out_data_d = data_c;
                out_ch_d   = ch_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_stream.sv
// Directed bench for mux_stream: select-mode scoreboard, N=3 range edge, and round-robin order.
module tb_mux_stream;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]  s4_sel;  logic [3:0] s4_iv, s4_ir;  logic [31:0] s4_id;
    logic        s4_ov, s4_or;  logic [7:0] s4_od;   logic [1:0]  s4_och;
    logic [1:0]  s3_sel;  logic [2:0] s3_iv, s3_ir;  logic [23:0] s3_id;
    logic        s3_ov, s3_or;  logic [7:0] s3_od;   logic [1:0]  s3_och;
    logic [1:0]  r4_sel;  logic [3:0] r4_iv, r4_ir;  logic [31:0] r4_id;
    logic        r4_ov, r4_or;  logic [7:0] r4_od;   logic [1:0]  r4_och;
    logic [1:0]  r3_sel;  logic [2:0] r3_iv, r3_ir;  logic [23:0] r3_id;
    logic        r3_ov, r3_or;  logic [7:0] r3_od;   logic [1:0]  r3_och;

    mux_stream #(.WIDTH(8), .N(4), .MODE(0)) u_s4 (
        .clk(clk), .rst_n(rst_n), .sel(s4_sel), .in_valid(s4_iv), .in_data(s4_id),
        .in_ready(s4_ir), .out_valid(s4_ov), .out_data(s4_od), .out_ch(s4_och), .out_ready(s4_or));
    mux_stream #(.WIDTH(8), .N(3), .MODE(0)) u_s3 (
        .clk(clk), .rst_n(rst_n), .sel(s3_sel), .in_valid(s3_iv), .in_data(s3_id),
        .in_ready(s3_ir), .out_valid(s3_ov), .out_data(s3_od), .out_ch(s3_och), .out_ready(s3_or));
    mux_stream #(.WIDTH(8), .N(4), .MODE(1)) u_r4 (
        .clk(clk), .rst_n(rst_n), .sel(r4_sel), .in_valid(r4_iv), .in_data(r4_id),
        .in_ready(r4_ir), .out_valid(r4_ov), .out_data(r4_od), .out_ch(r4_och), .out_ready(r4_or));
    mux_stream #(.WIDTH(8), .N(3), .MODE(1)) u_r3 (
        .clk(clk), .rst_n(rst_n), .sel(r3_sel), .in_valid(r3_iv), .in_data(r3_id),
        .in_ready(r3_ir), .out_valid(r3_ov), .out_data(r3_od), .out_ch(r3_och), .out_ready(r3_or));

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] d;
    } beat_t;

    beat_t sb[$];
    logic  mv;
    int    tests = 0;
    int    fails = 0;
    int    pops  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle of the 4-channel select-mode instance against a reference model and scoreboard.
    task automatic s4_cycle(input logic [1:0] s, input logic [3:0] v, input logic [31:0] d,
                            input logic r, output logic acc);
        logic  free;
        beat_t b;
        s4_sel = s; s4_iv = v; s4_id = d; s4_or = r;
        #1;
        free = !mv || r;
        acc  = free && v[s];
        check("s4_in_ready", 32'(s4_ir), free ? 32'(4'b0001 << s) : 32'd0);
        check("s4_out_valid", 32'(s4_ov), 32'(mv));
        if (mv && sb.size() > 0) begin
            b = sb[0];
            check("s4_out_data", 32'(s4_od), 32'(b.d));
            check("s4_out_ch", 32'(s4_och), 32'(b.ch));
            if (r) begin
                void'(sb.pop_front());
                pops++;
            end
        end
        if (acc) begin
            b.ch = s;
            b.d  = d[s*8 +: 8];
            sb.push_back(b);
        end
        if (free) mv = acc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        acc;
        logic [31:0] d;
        int          beat;
        int          cyc;
        int          seq4[6];
        int          seq3[4];

        seq4 = '{0, 1, 2, 3, 0, 1};
        seq3 = '{0, 1, 2, 0};
        mv = 1'b0;
        s4_sel = '0; s4_iv = '0; s4_id = '0; s4_or = 1'b1;
        s3_sel = '0; s3_iv = '0; s3_id = '0; s3_or = 1'b1;
        r4_sel = '0; r4_iv = '0; r4_id = '0; r4_or = 1'b1;
        r3_sel = '0; r3_iv = '0; r3_id = '0; r3_or = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_s4_valid", 32'(s4_ov), 32'd0);
        check("reset_r4_valid", 32'(r4_ov), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-stall discards the pending beat at once.
        s4_cycle(2'd1, 4'b0010, 32'h0000_7700, 1'b0, acc);
        s4_cycle(2'd1, 4'b0000, 32'h0, 1'b0, acc);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(s4_ov), 32'd0);
        check("rst_mid_data", 32'(s4_od), 32'd0);
        check("rst_mid_ch", 32'(s4_och), 32'd0);
        sb.delete();
        mv = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s4_cycle(2'd2, 4'b0100, 32'h00A5_0000, 1'b1, acc);
        check("post_rst_valid", 32'(s4_ov), 32'd1);
        check("post_rst_data", 32'(s4_od), 32'hA5);
        check("post_rst_ch", 32'(s4_och), 32'd2);
        s4_cycle(2'd0, 4'b0000, 32'h0, 1'b1, acc);

        // Backpressure: beat from ch1 holds while sel moves to 3; release loads ch3 on the same edge.
        s4_cycle(2'd1, 4'b0010, 32'h0000_3C00, 1'b1, acc);
        repeat (3) s4_cycle(2'd3, 4'hF, 32'hDD_CC_BB_AA, 1'b0, acc);
        s4_cycle(2'd3, 4'hF, 32'hDD_CC_BB_AA, 1'b1, acc);
        check("bp_reload_data", 32'(s4_od), 32'hDD);
        s4_cycle(2'd0, 4'b0000, 32'h0, 1'b1, acc);

        // Streaming with out_ready toggling: 16 ordered beats, drain, count.
        pops = 0;
        beat = 0;
        cyc  = 0;
        while (beat < 16 && cyc < 64) begin
            d = '0;
            d[(beat % 4)*8 +: 8] = 8'(8'h40 + beat);
            s4_cycle(2'(beat % 4), 4'(4'b0001 << (beat % 4)), d, (cyc % 2) == 0, acc);
            if (acc) beat++;
            cyc++;
        end
        repeat (2) s4_cycle(2'd0, 4'b0000, 32'h0, 1'b1, acc);
        check("stream_delivered", 32'(pops), 32'd16);

        // N=3 select: sel=3 is out of range and chooses nothing.
        s3_sel = 2'd3; s3_iv = 3'b111; s3_id = 24'h33_22_11; s3_or = 1'b1;
        #1;
        check("s3_oor_ready", 32'(s3_ir), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("s3_oor_valid", 32'(s3_ov), 32'd0);
        end
        s3_sel = 2'd2;
        #1;
        check("s3_top_ready", 32'(s3_ir), 32'b100);
        @(posedge clk);
        #1;
        check("s3_top_valid", 32'(s3_ov), 32'd1);
        check("s3_top_data", 32'(s3_od), 32'h33);
        check("s3_top_ch", 32'(s3_och), 32'd2);
        s3_sel = 2'd3;
        @(posedge clk);
        #1;
        check("s3_oor_drop", 32'(s3_ov), 32'd0);

        // Round-robin fairness with all channels valid.
        r4_iv = 4'hF; r4_id = 32'h13_12_11_10; r4_or = 1'b1;
        #1;
        check("rr_first_ready", 32'(r4_ir), 32'b0001);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("rr_seq_ch", 32'(r4_och), 32'(seq4[k]));
            check("rr_seq_data", 32'(r4_od), 32'(8'h10 + seq4[k]));
            check("rr_seq_valid", 32'(r4_ov), 32'd1);
        end
        // ptr=2 now; single request on ch2 moves ptr to 3.
        r4_iv = 4'b0100;
        @(posedge clk);
        #1;
        check("rr_to3_ch", 32'(r4_och), 32'd2);
        r4_iv = 4'b0101;
        #1;
        check("rr_wrap_ready", 32'(r4_ir), 32'b0001);
        @(posedge clk);
        #1;
        check("rr_wrap_ch", 32'(r4_och), 32'd0);
        check("rr_skip_ready", 32'(r4_ir), 32'b0100);
        @(posedge clk);
        #1;
        check("rr_skip_ch", 32'(r4_och), 32'd2);
        check("rr_back3_ready", 32'(r4_ir), 32'b0001);
        r4_or = 1'b0;
        #1;
        check("rr_stall_ready", 32'(r4_ir), 32'd0);
        @(posedge clk);
        #1;
        check("rr_stall_ch", 32'(r4_och), 32'd2);
        check("rr_stall_valid", 32'(r4_ov), 32'd1);
        r4_or = 1'b1;
        #1;
        check("rr_unstall_ready", 32'(r4_ir), 32'b0001);
        @(posedge clk);
        #1;
        check("rr_unstall_ch", 32'(r4_och), 32'd0);
        r4_iv = 4'b0000;
        #1;
        check("rr_idle_ready", 32'(r4_ir), 32'd0);
        @(posedge clk);
        #1;
        check("rr_idle_valid", 32'(r4_ov), 32'd0);

        // N=3 round-robin wraps modulo 3.
        r3_iv = 3'b111; r3_id = 24'hC2_C1_C0; r3_or = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("rr3_seq_ch", 32'(r3_och), 32'(seq3[k]));
            check("rr3_seq_data", 32'(r3_od), 32'(8'hC0 + seq3[k]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_stream.md
# mux_stream

Parametrised N-channel, WIDTH-bit stream multiplexer with a registered output stage and valid/ready handshakes. It generalises the plain 2:1 select mux used across the datapath. The channel is chosen either by an explicit select input or by round-robin arbitration. The output holds steady under backpressure. It sits between multiple producers (for example, write-back sources or request queues) and a single consumer port.

## Interface
- `WIDTH`, default 8: data width per channel.
- `N`, default 4: number of input channels, N ≥ 2; need not be a power of two.
- `MODE`, default 0: 0 = `MODE_SEL` (channel given by `sel`); 1 = `MODE_RR` (round-robin among valid inputs).
- `SELW` (derived localparam, not overridable): $clog2(N).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `sel`  in  SELW  channel select; used in `MODE_SEL` only.
- `in_valid`  in  N  per-channel valid.
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_ready`  out  N  per-channel ready; combinational.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  WIDTH  registered data.
- `out_ch`  out  SELW  source channel of the current output beat.
- `out_ready`  in  1  consumer accepts the beat.

## Operation
- `free = !out_valid || out_ready`: the output register may load this cycle.
- Chosen channel c, computed combinationally:
  - `MODE_SEL`: c = `sel`. If `sel` ≥ N, no channel is chosen.
  - `MODE_RR`: c = first i with `in_valid[i]=1`, scanning from `ptr` upward and wrapping modulo N. If no input is valid, no channel is chosen.
- `in_ready[i] = free && (i == c)`. All other `in_ready` bits are 0.
  - In `MODE_SEL`, `in_ready[sel]` may be 1 while `in_valid[sel]` is 0.
- Transfer on channel c when `in_valid[c] && in_ready[c]`. At the edge:
  - `out_data <= in_data[c]`, `out_ch <= c`, `out_valid <= 1`.
- If `free` and there is no transfer: `out_valid <= 0`. `out_data` and `out_ch` hold their last values.
- If not `free` (`out_valid=1`, `out_ready=0`): `out_valid`, `out_data`, `out_ch` all hold, and every `in_ready` is 0.
- Round-robin pointer `ptr` (SELW bits, `MODE_RR` only):
  - after a transfer from channel c: `ptr <= (c == N-1) ? 0 : c+1`;
  - otherwise `ptr` holds.
- Arithmetic: `ptr` and the scan index are taken modulo N, never modulo 2^SELW. Values ≥ N are never produced.

## Timing
- Reset (async assert, sync-release expected): `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=0`. `in_ready` follows the combinational rule, so it may be 1 immediately after reset.
- Latency: an input accepted at edge k is visible on `out_*` after edge k.
- Throughput: one beat per cycle while `out_ready=1` and a chosen input is valid.
- Simultaneous output drain and input load: one beat leaves and a new beat loads at the same edge. There is no bubble.
- `out_valid` never drops without a handshake. `out_data` and `out_ch` are stable while `out_valid && !out_ready`.
- `sel` changing while stalled has no effect until `free`. The channel is re-evaluated every cycle; there is no locking between beats.
- Reset mid-stall: the pending output beat is discarded and `ptr` returns to 0.

## Structure
- Shared package `mux_pkg`: `MODE_SEL`/`MODE_RR` constants and a `clog2` helper function if the toolchain lacks it.
- Sub-module `rr_pick`, instantiated only when `MODE_RR`:
  - inputs: N-bit request vector and `ptr`;
  - outputs: one-hot grant, encoded index, `any` flag;
  - purely combinational, scanning with wrap.
- The top level holds the output register, `ptr`, the free/ready logic, and the `in_data` slice select.

## Test plan
- Reset: assert `rst_n=0` mid-stream with `out_valid=1` → `out_valid=0`, `out_data=0`, `out_ch=0` immediately; after release with `MODE_SEL`, `sel=2`, `in_valid[2]=1`, data 8'hA5 → after one edge `out_valid=1`, `out_data=A5`, `out_ch=2`.
- `MODE_SEL` backpressure: load 8'h3C from channel 1 with `out_ready=0` for 3 cycles while `sel` changes to 3 and `in_valid=4'hF` → `out_data` stays 3C, `out_ch` stays 1, `in_ready=0`; on `out_ready=1` the same edge loads channel 3.
- `MODE_SEL`, N=3, `sel=3`: all `in_valid=1` → `in_ready=3'b000`, `out_valid` stays 0.
- `MODE_RR` fairness, N=4, `in_valid=4'hF` held, `out_ready=1` → `out_ch` sequence 0,1,2,3,0 on consecutive cycles, one beat per cycle.
- `MODE_RR` wrap and skip: `ptr=3`, `in_valid=4'b0101` → grant to channel 0; next cycle grant to channel 2; then `ptr=3` again.
- Streaming throughput: 16 beats with `out_ready` toggling 1,0,1,0 → all 16 delivered in order with no duplicates or drops, and `out_valid` never deasserted while `out_ready=0`.
